uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter HOLD_TIMEOUT, 1024, clk cycles a locked owner may stay idle before its lock is released (>=1).
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester byte-valid.
REQ-006 req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_last  input  NUM_REQ  marks the byte as the last of a packet; qualified by req_valid.
REQ-008 req_ready  output  NUM_REQ  per-requester accept; a byte transfers when req_valid[i] and req_ready[i] are both high.
REQ-009 tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-010 tx_data  output  8  byte to the transmitter; stable from the tx_start cycle until tx_done_tick.
REQ-011 tx_done_tick  input  1  one-cycle completion pulse from the transmitter.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 grant_id  output  clog2(NUM_REQ)  index of the current owner; valid while busy.

Function
REQ-014 The FSM SHALL have four states: IDLE, START, WAIT and HOLD.
REQ-015 IDLE: req_ready SHALL be one-hot on the first valid requester in round-robin order from rr_ptr, or all-zero if none is valid; on transfer, latch the byte, req_last and the owner, then go to START.
REQ-016 START: tx_start=1 for exactly one cycle, then go to WAIT.
REQ-017 WAIT: on tx_done_tick, if the latched last=1 go to IDLE with rr_ptr=(owner+1) mod NUM_REQ; otherwise go to HOLD with the timeout counter cleared.
REQ-018 HOLD: req_ready SHALL be asserted only for the owner, and all other requesters SHALL be ignored.
REQ-019 HOLD transfer: latch the byte and req_last, then go to START.
REQ-020 HOLD with no owner transfer: the counter increments each cycle; on reaching HOLD_TIMEOUT-1, go to IDLE with rr_ptr=(owner+1) mod NUM_REQ.
REQ-021 req_ready SHALL be combinational from state, rr_ptr, owner and req_valid; it SHALL be zero in START and WAIT.
REQ-022 tx_start SHALL be registered; latency from a transfer cycle to tx_start=1 is exactly 1 cycle.
REQ-023 tx_done_tick outside WAIT SHALL be ignored.
REQ-024 A simultaneous valid from several requesters in IDLE SHALL grant only one of them; the others see req_ready=0 and hold.
REQ-025 rr_ptr SHALL wrap from NUM_REQ-1 to 0.
REQ-026 The timeout counter SHALL be sized clog2(HOLD_TIMEOUT+1) and SHALL saturate, never wrap.

Reset
REQ-027 On reset the block SHALL enter IDLE and clear rr_ptr=0, owner=0, timeout counter=0, tx_start=0, tx_data=0, busy=0, grant_id=0 and req_ready=0.
REQ-028 Reset mid-transmission SHALL abort immediately with no tx_start pulse; the transmitter is reset by the same signal.

Structure
REQ-029 The state encoding (IDLE=0, START=1, WAIT=2, HOLD=3) and the byte width of 8 SHALL live in the shared uart_pkg package.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (inputs: request vector, pointer; outputs: one-hot grant, index, any).

Verification
REQ-031 Reset, then req_valid=4'b0001, data 8'hA5, last=1 -> req_ready[0] high in the same cycle, tx_start one cycle later, tx_data=8'hA5 until done, busy=0 after tx_done_tick.
REQ-032 req_valid=4'b1111, all last=1, rr_ptr=0, done returned 10 cycles after each start -> grant order 0,1,2,3,0.
REQ-033 Requester 2 sends 3 bytes 8'h01,8'h02,8'h03 (last on 8'h03) while requester 1 is valid -> requester 1 is not granted until after the third done; then grant_id=1.
REQ-034 Requester 0 sends last=0 then drops valid, HOLD_TIMEOUT=8 -> IDLE after 8 HOLD cycles, rr_ptr=1, and a waiting requester 3 is granted next.
REQ-035 Spurious tx_done_tick in IDLE and in START -> no state change and no extra tx_start.
REQ-036 reset asserted in WAIT -> next edge shows IDLE, tx_start=0, req_ready=0, rr_ptr=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM state encoding and byte width.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping. Purely combinational.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters; a packet owner keeps the lock until last byte or idle timeout.
// tx_start follows an accepted byte by 1 cycle; req_ready is low while a byte is in flight, so senders hold.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_start,
  output logic [BYTE_W-1:0]           tx_data,
  input  logic                        tx_done_tick,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(HOLD_TIMEOUT);

  state_t              state, state_nxt;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       owner;
  logic                last_q;
  logic [CW-1:0]       hold_cnt;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                xfer;
  logic [IW-1:0]       xfer_idx;
  logic                release_lock;
  logic [BYTE_W-1:0]   req_byte [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign req_byte[i] = req_data[BYTE_W*i +: BYTE_W];
  end

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] cur);
    if (int'(cur) == NUM_REQ - 1) return '0;
    return cur + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    xfer         = 1'b0;
    xfer_idx     = owner;
    release_lock = 1'b0;
    case (state)
      IDLE: begin
        req_ready = pick_grant;
        if (pick_any) begin
          xfer      = 1'b1;
          xfer_idx  = pick_idx;
          state_nxt = START;
        end
      end
      START: state_nxt = WAIT;
      WAIT: begin
        if (tx_done_tick) begin
          release_lock = last_q;
          state_nxt    = last_q ? IDLE : HOLD;
        end
      end
      HOLD: begin
        // Only the lock owner is served; everyone else waits out the packet.
        req_ready[owner] = req_valid[owner];
        if (req_valid[owner]) begin
          xfer      = 1'b1;
          state_nxt = START;
        end else if (hold_cnt == CNT_LAST) begin
          release_lock = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      owner    <= '0;
      last_q   <= 1'b0;
      hold_cnt <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= xfer;
      if (xfer) begin
        owner   <= xfer_idx;
        tx_data <= req_byte[xfer_idx];
        last_q  <= req_last[xfer_idx];
      end
      if (state == WAIT) hold_cnt <= '0;
      else if (state == HOLD && hold_cnt != CNT_SAT) hold_cnt <= hold_cnt + 1'b1;
      if (release_lock) rr_ptr <= next_idx(owner);
    end
  end

  assign busy     = (state != IDLE);
  assign grant_id = owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round-robin order, packet lock, hold timeout, spurious done, reset abort.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int HOLD_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done_tick = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .HOLD_TIMEOUT(HOLD_TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]        = v;
    req_data[8*i +: 8]  = d;
    req_last[i]         = l;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input string tag);
    int k;
    k = 0;
    while (tx_start !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_start"}, 32'(tx_start), 32'd1);
  endtask

  // Called at a negedge; done is high across exactly one rising edge.
  task automatic done_pulse();
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset state
    cycles(2);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h0);
    reset = 1'b0;
    cycles(1);

    // Single byte from requester 0
    drive(0, 1'b1, 8'hA5, 1'b1);
    #1 check("single_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("single_start", 32'(tx_start), 32'h1);
    check("single_data", 32'(tx_data), 32'hA5);
    check("single_busy", 32'(busy), 32'h1);
    check("single_grant", 32'(grant_id), 32'h0);
    drive(0, 1'b0, 8'h00, 1'b0);
    cycles(1);
    check("single_start_once", 32'(tx_start), 32'h0);
    check("single_ready_wait", 32'(req_ready), 32'h0);
    cycles(5);
    check("single_data_hold", 32'(tx_data), 32'hA5);
    done_pulse();
    check("single_idle", 32'(busy), 32'h0);

    // Round-robin across all four with rr_ptr back at 0
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 8'(8'h10 + i), 1'b1);
    #1 check("rr_onehot", 32'(req_ready), 32'h1);
    for (int g = 0; g < 5; g++) begin
      wait_start("rr");
      check($sformatf("rr_grant%0d", g), 32'(grant_id), 32'(exp_order[g]));
      check($sformatf("rr_data%0d", g), 32'(tx_data), 32'(8'h10 + exp_order[g]));
      if (g == 4) req_valid = '0;
      cycles(9);
      done_pulse();
    end

    // Requester 2 holds the lock for a 3-byte packet while requester 1 waits (rr_ptr=1)
    drive(2, 1'b1, 8'h01, 1'b0);
    wait_start("pkt_b1");
    check("pkt_b1_grant", 32'(grant_id), 32'h2);
    check("pkt_b1_data", 32'(tx_data), 32'h01);
    drive(2, 1'b1, 8'h02, 1'b0);
    drive(1, 1'b1, 8'h77, 1'b1);
    cycles(3);
    check("pkt_wait_ready", 32'(req_ready), 32'h0);
    done_pulse();
    check("pkt_hold_ready", 32'(req_ready), 32'h4);
    wait_start("pkt_b2");
    check("pkt_b2_grant", 32'(grant_id), 32'h2);
    check("pkt_b2_data", 32'(tx_data), 32'h02);
    drive(2, 1'b1, 8'h03, 1'b1);
    cycles(3);
    done_pulse();
    wait_start("pkt_b3");
    check("pkt_b3_grant", 32'(grant_id), 32'h2);
    check("pkt_b3_data", 32'(tx_data), 32'h03);
    drive(2, 1'b0, 8'h00, 1'b0);
    cycles(3);
    done_pulse();
    check("pkt_after_ready", 32'(req_ready), 32'h2);
    wait_start("pkt_r1");
    check("pkt_r1_grant", 32'(grant_id), 32'h1);
    check("pkt_r1_data", 32'(tx_data), 32'h77);
    drive(1, 1'b0, 8'h00, 1'b0);
    cycles(2);
    done_pulse();

    // Hold timeout: requester 0 goes quiet mid-packet, requester 3 waits (rr_ptr=2)
    drive(0, 1'b1, 8'h5A, 1'b0);
    wait_start("to_r0");
    check("to_r0_grant", 32'(grant_id), 32'h0);
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(3, 1'b1, 8'hC3, 1'b1);
    cycles(2);
    done_pulse();
    check("to_hold_busy", 32'(busy), 32'h1);
    check("to_hold_ignore", 32'(req_ready), 32'h0);
    cycles(7);
    check("to_hold_last", 32'(busy), 32'h1);
    cycles(1);
    check("to_released", 32'(busy), 32'h0);
    check("to_ready3", 32'(req_ready), 32'h8);
    wait_start("to_r3");
    check("to_r3_grant", 32'(grant_id), 32'h3);
    check("to_r3_data", 32'(tx_data), 32'hC3);
    drive(3, 1'b0, 8'h00, 1'b0);
    cycles(2);
    done_pulse();
    check("to_r3_idle", 32'(busy), 32'h0);

    // Spurious done in IDLE, then in START
    done_pulse();
    check("sp_idle_busy", 32'(busy), 32'h0);
    check("sp_idle_start", 32'(tx_start), 32'h0);
    drive(1, 1'b1, 8'h11, 1'b1);
    cycles(1);
    check("sp_start", 32'(tx_start), 32'h1);
    drive(1, 1'b0, 8'h00, 1'b0);
    done_pulse();
    check("sp_start_busy", 32'(busy), 32'h1);
    check("sp_start_once", 32'(tx_start), 32'h0);
    cycles(3);
    check("sp_still_wait", 32'(busy), 32'h1);
    check("sp_no_extra", 32'(tx_start), 32'h0);
    done_pulse();
    check("sp_done_idle", 32'(busy), 32'h0);

    // Reset in WAIT (rr_ptr=2 before reset)
    drive(2, 1'b1, 8'h22, 1'b1);
    wait_start("rw");
    check("rw_grant", 32'(grant_id), 32'h2);
    drive(2, 1'b0, 8'h00, 1'b0);
    cycles(1);
    reset = 1'b1;
    #1;
    check("rw_async_busy", 32'(busy), 32'h0);
    check("rw_async_data", 32'(tx_data), 32'h0);
    @(posedge clk);
    #1;
    check("rw_edge_busy", 32'(busy), 32'h0);
    check("rw_edge_start", 32'(tx_start), 32'h0);
    check("rw_edge_ready", 32'(req_ready), 32'h0);
    check("rw_edge_grant", 32'(grant_id), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 8'(8'h30 + i), 1'b1);
    #1 check("rw_ptr0_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("rw_ptr0_grant", 32'(grant_id), 32'h0);
    check("rw_ptr0_data", 32'(tx_data), 32'h30);
    req_valid = '0;
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
